// File: rtl/ram_arbiter_if.sv
// Bus bundle between the two requesters (m0 = core LSU, m1 = DMA/debug),
// the arbiter and the byte-lane data RAM wrapper.
interface ram_arbiter_if;
  logic        m0_req;
  logic        m0_we;
  logic [31:0] m0_addr;
  logic [1:0]  m0_size;
  logic        m0_unsigned;
  logic [31:0] m0_wdata;
  logic        m0_gnt;
  logic        m0_rvalid;
  logic [31:0] m0_rdata;
  logic        m0_err;

  logic        m1_req;
  logic        m1_we;
  logic [31:0] m1_addr;
  logic [1:0]  m1_size;
  logic        m1_unsigned;
  logic [31:0] m1_wdata;
  logic        m1_gnt;
  logic        m1_rvalid;
  logic [31:0] m1_rdata;
  logic        m1_err;

  logic [3:0]  ram_wen;
  logic [31:0] ram_w_addr;
  logic [31:0] ram_w_data;
  logic        ram_ren;
  logic [31:0] ram_r_addr;
  logic [31:0] ram_r_data;

  // Requester/RAM side: drives requests and RAM read data
  modport master (
    output m0_req, m0_we, m0_addr, m0_size, m0_unsigned, m0_wdata,
    input  m0_gnt, m0_rvalid, m0_rdata, m0_err,
    output m1_req, m1_we, m1_addr, m1_size, m1_unsigned, m1_wdata,
    input  m1_gnt, m1_rvalid, m1_rdata, m1_err,
    input  ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr,
    output ram_r_data
  );

  // Arbiter side
  modport slave (
    input  m0_req, m0_we, m0_addr, m0_size, m0_unsigned, m0_wdata,
    output m0_gnt, m0_rvalid, m0_rdata, m0_err,
    input  m1_req, m1_we, m1_addr, m1_size, m1_unsigned, m1_wdata,
    output m1_gnt, m1_rvalid, m1_rdata, m1_err,
    output ram_wen, ram_w_addr, ram_w_data, ram_ren, ram_r_addr,
    input  ram_r_data
  );
endinterface

// File: rtl/ram_arbiter.sv
// Two-requester arbiter for the 16 KiB byte-lane data RAM.
// Grants one access per cycle, steers byte/half/word writes onto the RAM
// lanes, and returns aligned, extended read data (or an error) one cycle
// after the grant.
// Optional feature macro: RAM_ARB_RR_EN (round-robin instead of m0 priority).
module ram_arbiter #(
  parameter int AW = 12,
  parameter int DW = 32
) (
  input  logic   clk,
  input  logic   rst,
  ram_arbiter_if.slave bus
);

  // Only the 32-bit, four-lane organisation is supported; AW must leave
  // room for the byte offset inside a 32-bit address.
  generate
    if (DW != 32 || AW < 1 || AW > 30) begin : g_bad_param
      $error("ram_arbiter: unsupported AW/DW combination");
    end
  endgenerate

  localparam logic [1:0] SZ_BYTE = 2'd0;
  localparam logic [1:0] SZ_HALF = 2'd1;
  localparam logic [1:0] SZ_WORD = 2'd2;

  logic          w_gnt0;
  logic          w_gnt1;
  logic          w_any;
  logic          w_we;
  logic [31:0]   w_addr;
  logic [1:0]    w_size;
  logic          w_uns;
  logic [31:0]   w_wdata;
  logic          w_legal;
  logic [31:0]   w_word_addr;

  logic          r_rsp_valid;
  logic          r_rsp_err;
  logic          r_rsp_owner;
  logic [1:0]    r_rsp_off;
  logic [1:0]    r_rsp_size;
  logic          r_rsp_uns;

  logic [DW-1:0] w_shift;
  logic [DW-1:0] w_ext;
  logic [DW-1:0] w_rdata;

`ifdef RAM_ARB_RR_EN
  // r_last: 0 = m0 won the most recent grant, 1 = m1
  logic r_last;

  // Track the last winner so a conflict goes to the other requester
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_last <= 1'b0;
    end else if (w_any) begin
      r_last <= w_gnt1;
    end
  end

  // Round-robin grant: on conflict, the requester not granted last wins
  always_comb begin
    w_gnt0 = bus.m0_req & (~bus.m1_req | r_last);
    w_gnt1 = bus.m1_req & (~bus.m0_req | ~r_last);
  end
`else
  // Fixed-priority grant: m0 always wins a conflict
  always_comb begin
    w_gnt0 = bus.m0_req;
    w_gnt1 = bus.m1_req & ~bus.m0_req;
  end
`endif

  assign w_any      = w_gnt0 | w_gnt1;
  assign bus.m0_gnt = w_gnt0;
  assign bus.m1_gnt = w_gnt1;

  // Select the attributes of the granted requester
  always_comb begin
    if (w_gnt1) begin
      w_we    = bus.m1_we;
      w_addr  = bus.m1_addr;
      w_size  = bus.m1_size;
      w_uns   = bus.m1_unsigned;
      w_wdata = bus.m1_wdata;
    end else begin
      w_we    = bus.m0_we;
      w_addr  = bus.m0_addr;
      w_size  = bus.m0_size;
      w_uns   = bus.m0_unsigned;
      w_wdata = bus.m0_wdata;
    end
  end

  assign w_word_addr = {w_addr[31:2], 2'b00};

  // Alignment / size legality of the selected access
  always_comb begin
    case (w_size)
      SZ_BYTE: w_legal = 1'b1;
      SZ_HALF: w_legal = ~w_addr[0];
      SZ_WORD: w_legal = (w_addr[1:0] == 2'b00);
      default: w_legal = 1'b0;
    endcase
  end

  // Drive the RAM port; everything stays zero unless a legal access is granted
  always_comb begin
    bus.ram_wen    = 4'b0000;
    bus.ram_w_addr = '0;
    bus.ram_w_data = '0;
    bus.ram_ren    = 1'b0;
    bus.ram_r_addr = '0;
    if (w_any && w_legal) begin
      if (w_we) begin
        bus.ram_w_addr = w_word_addr;
        case (w_size)
          SZ_BYTE: begin
            bus.ram_wen    = 4'b0001 << w_addr[1:0];
            bus.ram_w_data = {4{w_wdata[7:0]}};
          end
          SZ_HALF: begin
            bus.ram_wen    = 4'b0011 << w_addr[1:0];
            bus.ram_w_data = {2{w_wdata[15:0]}};
          end
          default: begin
            bus.ram_wen    = 4'b1111;
            bus.ram_w_data = w_wdata;
          end
        endcase
      end else begin
        bus.ram_ren    = 1'b1;
        bus.ram_r_addr = w_word_addr;
      end
    end
  end

  // Response tag: legal reads and all illegal accesses answer next cycle
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_rsp_valid <= 1'b0;
      r_rsp_err   <= 1'b0;
      r_rsp_owner <= 1'b0;
      r_rsp_off   <= 2'b00;
      r_rsp_size  <= 2'b00;
      r_rsp_uns   <= 1'b0;
    end else begin
      r_rsp_valid <= w_any & (~w_we | ~w_legal);
      r_rsp_err   <= w_any & ~w_legal;
      if (w_any) begin
        r_rsp_owner <= w_gnt1;
        r_rsp_off   <= w_addr[1:0];
        r_rsp_size  <= w_size;
        r_rsp_uns   <= w_uns;
      end
    end
  end

  assign w_shift = bus.ram_r_data >> {r_rsp_off, 3'b000};

  // Truncate the lane-aligned data to the access size and extend it
  always_comb begin
    case (r_rsp_size)
      SZ_BYTE: w_ext = r_rsp_uns ? {24'h0, w_shift[7:0]}
                                 : {{24{w_shift[7]}}, w_shift[7:0]};
      SZ_HALF: w_ext = r_rsp_uns ? {16'h0, w_shift[15:0]}
                                 : {{16{w_shift[15]}}, w_shift[15:0]};
      default: w_ext = w_shift;
    endcase
  end

  assign w_rdata       = r_rsp_err ? '0 : w_ext;

  assign bus.m0_rvalid = r_rsp_valid & ~r_rsp_owner;
  assign bus.m1_rvalid = r_rsp_valid &  r_rsp_owner;
  assign bus.m0_err    = r_rsp_err   & ~r_rsp_owner;
  assign bus.m1_err    = r_rsp_err   &  r_rsp_owner;
  assign bus.m0_rdata  = bus.m0_rvalid ? w_rdata : '0;
  assign bus.m1_rdata  = bus.m1_rvalid ? w_rdata : '0;

endmodule

// File: tb/tb_ram_arbiter.sv
// Directed self-checking bench for ram_arbiter with a behavioural RAM model.
module tb_ram_arbiter;

  logic clk;
  logic rst;
  int   checks;
  int   failures;

  ram_arbiter_if bus ();

  ram_arbiter #(.AW(12), .DW(32)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus.slave)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  // Behavioural RAM: byte-lane writes, one-cycle read latency, no reset
  logic [31:0] mem [0:4095];
  initial begin
    for (int i = 0; i < 4096; i++) mem[i] = 32'h0;
    bus.ram_r_data = 32'h0;
  end
  always @(posedge clk) begin
    for (int b = 0; b < 4; b++)
      if (bus.ram_wen[b]) mem[bus.ram_w_addr[13:2]][8*b +: 8] <= bus.ram_w_data[8*b +: 8];
    if (bus.ram_ren) bus.ram_r_data <= mem[bus.ram_r_addr[13:2]];
  end

  task automatic set_m0(input logic req, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    bus.m0_req = req; bus.m0_we = we; bus.m0_addr = addr;
    bus.m0_size = size; bus.m0_unsigned = uns; bus.m0_wdata = wdata;
  endtask

  task automatic set_m1(input logic req, input logic we, input logic [31:0] addr,
                        input logic [1:0] size, input logic uns, input logic [31:0] wdata);
    bus.m1_req = req; bus.m1_we = we; bus.m1_addr = addr;
    bus.m1_size = size; bus.m1_unsigned = uns; bus.m1_wdata = wdata;
  endtask

  task automatic test_reset;
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    rst = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk); #1;
    checks++; if (bus.m0_rvalid !== 1'b0) begin $display("FAIL reset_m0_rvalid got=%b exp=0", bus.m0_rvalid); failures++; end
    checks++; if (bus.m1_rvalid !== 1'b0) begin $display("FAIL reset_m1_rvalid got=%b exp=0", bus.m1_rvalid); failures++; end
    checks++; if ({bus.m0_err, bus.m1_err} !== 2'b00) begin $display("FAIL reset_err got=%b exp=00", {bus.m0_err, bus.m1_err}); failures++; end
    checks++; if ({bus.ram_wen, bus.ram_ren} !== 5'b0) begin $display("FAIL reset_ram_en got=%b exp=00000", {bus.ram_wen, bus.ram_ren}); failures++; end
    rst = 1'b0;
    @(negedge clk);
  endtask

  task automatic test_word;
    set_m0(1, 1, 32'h10, 2'd2, 0, 32'hDEADBEEF); #1;
    checks++; if (bus.m0_gnt !== 1'b1) begin $display("FAIL sw_gnt got=%b exp=1", bus.m0_gnt); failures++; end
    checks++; if (bus.ram_wen !== 4'b1111) begin $display("FAIL sw_wen got=%b exp=1111", bus.ram_wen); failures++; end
    checks++; if (bus.ram_w_addr !== 32'h10) begin $display("FAIL sw_waddr got=%h exp=00000010", bus.ram_w_addr); failures++; end
    checks++; if (bus.ram_w_data !== 32'hDEADBEEF) begin $display("FAIL sw_wdata got=%h exp=deadbeef", bus.ram_w_data); failures++; end
    checks++; if (bus.ram_ren !== 1'b0) begin $display("FAIL sw_ren got=%b exp=0", bus.ram_ren); failures++; end
    @(posedge clk); #1;
    checks++; if (bus.m0_rvalid !== 1'b0) begin $display("FAIL sw_no_rsp got=%b exp=0", bus.m0_rvalid); failures++; end
    @(negedge clk);
    set_m0(1, 0, 32'h10, 2'd2, 0, 0); #1;
    checks++; if ({bus.ram_ren, bus.ram_wen} !== 5'b10000) begin $display("FAIL lw_en got=%b exp=10000", {bus.ram_ren, bus.ram_wen}); failures++; end
    checks++; if (bus.ram_r_addr !== 32'h10) begin $display("FAIL lw_raddr got=%h exp=00000010", bus.ram_r_addr); failures++; end
    @(posedge clk); #1;
    checks++; if (bus.m0_rvalid !== 1'b1) begin $display("FAIL lw_rvalid got=%b exp=1", bus.m0_rvalid); failures++; end
    checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin $display("FAIL lw_rdata got=%h exp=deadbeef", bus.m0_rdata); failures++; end
    checks++; if ({bus.m1_rvalid, bus.m1_rdata} !== 33'h0) begin $display("FAIL lw_m1_quiet got=%b/%h exp=0/0", bus.m1_rvalid, bus.m1_rdata); failures++; end
    @(negedge clk);
    set_m0(1, 0, 32'h4010, 2'd2, 0, 0); #1;
    checks++; if (bus.ram_r_addr !== 32'h4010) begin $display("FAIL wrap_raddr got=%h exp=00004010", bus.ram_r_addr); failures++; end
    @(posedge clk); #1;
    checks++; if (bus.m0_rdata !== 32'hDEADBEEF) begin $display("FAIL wrap_rdata got=%h exp=deadbeef", bus.m0_rdata); failures++; end
    @(negedge clk);
    set_m0(0, 0, 0, 0, 0, 0); #1;
    checks++; if ({bus.ram_ren, bus.ram_r_addr} !== 33'h0) begin $display("FAIL idle_read_port got=%b/%h exp=0/0", bus.ram_ren, bus.ram_r_addr); failures++; end
    @(posedge clk); #1;
    checks++; if (bus.m0_rvalid !== 1'b0) begin $display("FAIL lw_one_cycle got=%b exp=0", bus.m0_rvalid); failures++; end
    @(negedge clk);
  endtask

  // Byte write then back-to-back LB/LBU/LW with the request held
  task automatic test_byte;
    set_m0(1, 1, 32'h13, 2'd0, 0, 32'h000000A5); #1;
    checks++; if (bus.ram_wen !== 4'b1000) begin $display("FAIL sb_wen got=%b exp=1000", bus.ram_wen); failures++; end
    checks++; if (bus.ram_w_data !== 32'hA5A5A5A5) begin $display("FAIL sb_wdata got=%h exp=a5a5a5a5", bus.ram_w_data); failures++; end
    checks++; if (bus.ram_w_addr !== 32'h10) begin $display("FAIL sb_waddr got=%h exp=00000010", bus.ram_w_addr); failures++; end
    @(negedge clk);
    set_m0(1, 0, 32'h13, 2'd0, 0, 0);
    @(posedge clk); #1;
    checks++; if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'hFFFFFFA5}) begin $display("FAIL lb_rdata got=%b/%h exp=1/ffffffa5", bus.m0_rvalid, bus.m0_rdata); failures++; end
    @(negedge clk);
    set_m0(1, 0, 32'h13, 2'd0, 1, 0);
    @(posedge clk); #1;
    checks++; if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'h000000A5}) begin $display("FAIL lbu_rdata got=%b/%h exp=1/000000a5", bus.m0_rvalid, bus.m0_rdata); failures++; end
    @(negedge clk);
    set_m0(1, 0, 32'h10, 2'd2, 0, 0);
    @(posedge clk); #1;
    checks++; if (bus.m0_rdata !== 32'hA5ADBEEF) begin $display("FAIL sb_neighbours got=%h exp=a5adbeef", bus.m0_rdata); failures++; end
    @(negedge clk);
    set_m0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_half;
    set_m1(1, 1, 32'h22, 2'd1, 0, 32'h00008001); #1;
    checks++; if ({bus.m1_gnt, bus.m0_gnt} !== 2'b10) begin $display("FAIL sh_gnt got=%b exp=10", {bus.m1_gnt, bus.m0_gnt}); failures++; end
    checks++; if (bus.ram_wen !== 4'b1100) begin $display("FAIL sh_wen got=%b exp=1100", bus.ram_wen); failures++; end
    checks++; if (bus.ram_w_data !== 32'h80018001) begin $display("FAIL sh_wdata got=%h exp=80018001", bus.ram_w_data); failures++; end
    checks++; if (bus.ram_w_addr !== 32'h20) begin $display("FAIL sh_waddr got=%h exp=00000020", bus.ram_w_addr); failures++; end
    @(negedge clk);
    set_m1(1, 0, 32'h22, 2'd1, 0, 0);
    @(posedge clk); #1;
    checks++; if ({bus.m1_rvalid, bus.m1_rdata} !== {1'b1, 32'hFFFF8001}) begin $display("FAIL lh_rdata got=%b/%h exp=1/ffff8001", bus.m1_rvalid, bus.m1_rdata); failures++; end
    checks++; if (bus.m0_rvalid !== 1'b0) begin $display("FAIL lh_m0_quiet got=%b exp=0", bus.m0_rvalid); failures++; end
    @(negedge clk);
    set_m1(1, 0, 32'h22, 2'd1, 1, 0);
    @(posedge clk); #1;
    checks++; if ({bus.m1_rvalid, bus.m1_rdata} !== {1'b1, 32'h00008001}) begin $display("FAIL lhu_rdata got=%b/%h exp=1/00008001", bus.m1_rvalid, bus.m1_rdata); failures++; end
    @(negedge clk);
    set_m1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_illegal;
    set_m0(1, 0, 32'h5, 2'd2, 0, 0); #1;
    checks++; if (bus.m0_gnt !== 1'b1) begin $display("FAIL ill_lw_gnt got=%b exp=1", bus.m0_gnt); failures++; end
    checks++; if ({bus.ram_ren, bus.ram_wen} !== 5'b0) begin $display("FAIL ill_lw_en got=%b exp=00000", {bus.ram_ren, bus.ram_wen}); failures++; end
    @(posedge clk); #1;
    checks++; if ({bus.m0_err, bus.m0_rvalid, bus.m0_rdata} !== {2'b11, 32'h0}) begin $display("FAIL ill_lw_rsp got=%b%b/%h exp=11/00000000", bus.m0_err, bus.m0_rvalid, bus.m0_rdata); failures++; end
    @(negedge clk);
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(1, 1, 32'h7, 2'd1, 0, 32'h1234); #1;
    checks++; if ({bus.ram_ren, bus.ram_wen} !== 5'b0) begin $display("FAIL ill_sh_en got=%b exp=00000", {bus.ram_ren, bus.ram_wen}); failures++; end
    @(posedge clk); #1;
    checks++; if ({bus.m1_err, bus.m1_rvalid, bus.m1_rdata} !== {2'b11, 32'h0}) begin $display("FAIL ill_sh_rsp got=%b%b/%h exp=11/00000000", bus.m1_err, bus.m1_rvalid, bus.m1_rdata); failures++; end
    checks++; if ({bus.m0_err, bus.m0_rvalid} !== 2'b00) begin $display("FAIL ill_sh_m0_quiet got=%b exp=00", {bus.m0_err, bus.m0_rvalid}); failures++; end
    @(negedge clk);
    set_m1(1, 0, 32'h20, 2'd3, 0, 0); #1;
    checks++; if (bus.ram_ren !== 1'b0) begin $display("FAIL ill_size3_ren got=%b exp=0", bus.ram_ren); failures++; end
    @(posedge clk); #1;
    checks++; if (bus.m1_err !== 1'b1) begin $display("FAIL ill_size3_err got=%b exp=1", bus.m1_err); failures++; end
    @(negedge clk);
    set_m1(0, 0, 0, 0, 0, 0);
    @(posedge clk); #1;
    checks++; if ({bus.m0_err, bus.m1_err} !== 2'b00) begin $display("FAIL ill_err_one_cycle got=%b exp=00", {bus.m0_err, bus.m1_err}); failures++; end
    @(negedge clk);
  endtask

  // Both request reads for four cycles; reset first so the RR pointer is m0
  task automatic test_conflict;
    logic exp1;
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    set_m0(1, 0, 32'h10, 2'd2, 0, 0);
    set_m1(1, 0, 32'h20, 2'd2, 0, 0);
    for (int i = 0; i < 4; i++) begin
`ifdef RAM_ARB_RR_EN
      exp1 = (i % 2 == 0);
`else
      exp1 = 1'b0;
`endif
      #1;
      checks++; if ({bus.m0_gnt, bus.m1_gnt} !== {~exp1, exp1}) begin $display("FAIL conflict_gnt[%0d] got=%b exp=%b", i, {bus.m0_gnt, bus.m1_gnt}, {~exp1, exp1}); failures++; end
      @(posedge clk); #1;
      if (exp1) begin
        checks++; if ({bus.m1_rvalid, bus.m0_rvalid, bus.m1_rdata} !== {2'b10, 32'h80010000}) begin $display("FAIL conflict_rsp_m1[%0d] got=%b%b/%h exp=10/80010000", i, bus.m1_rvalid, bus.m0_rvalid, bus.m1_rdata); failures++; end
      end else begin
        checks++; if ({bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata} !== {2'b10, 32'hA5ADBEEF}) begin $display("FAIL conflict_rsp_m0[%0d] got=%b%b/%h exp=10/a5adbeef", i, bus.m0_rvalid, bus.m1_rvalid, bus.m0_rdata); failures++; end
      end
      @(negedge clk);
    end
    set_m0(0, 0, 0, 0, 0, 0);
    set_m1(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  task automatic test_reset_mid_read;
    set_m0(1, 0, 32'h10, 2'd2, 0, 0);
    @(posedge clk); #1;
    set_m0(0, 0, 0, 0, 0, 0);
    rst = 1'b1; #1;
    checks++; if (bus.m0_rvalid !== 1'b0) begin $display("FAIL rst_async_drop got=%b exp=0", bus.m0_rvalid); failures++; end
    @(negedge clk);
    rst = 1'b0;
    for (int i = 0; i < 2; i++) begin
      @(posedge clk); #1;
      checks++; if ({bus.m0_rvalid, bus.m1_rvalid} !== 2'b00) begin $display("FAIL rst_no_rsp[%0d] got=%b exp=00", i, {bus.m0_rvalid, bus.m1_rvalid}); failures++; end
    end
    @(negedge clk);
    set_m0(1, 0, 32'h10, 2'd2, 0, 0);
    @(posedge clk); #1;
    checks++; if ({bus.m0_rvalid, bus.m0_rdata} !== {1'b1, 32'hA5ADBEEF}) begin $display("FAIL rst_after_read got=%b/%h exp=1/a5adbeef", bus.m0_rvalid, bus.m0_rdata); failures++; end
    @(negedge clk);
    set_m0(0, 0, 0, 0, 0, 0);
    @(negedge clk);
  endtask

  initial begin
    checks   = 0;
    failures = 0;
    rst      = 1'b1;
    test_reset();
    test_word();
    test_byte();
    test_half();
    test_illegal();
    test_conflict();
    test_reset_mid_read();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  // Absolute time bound so the run always ends on its own
  initial begin
    #100000;
    $display("FAIL timeout got=running exp=finished");
    failures++;
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
